// File: rtl/matrix_fill_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_fill_loader
//  Description : Fetches ROWS+1 64-bit words over an Avalon-style read port
//                (one read outstanding) and writes them byte by byte, LSB
//                byte first, into the vector-B FIFO (word 0) and the matrix-A
//                row FIFOs (words 1..ROWS). Signals completion with done.
//                Optional readdatavalid watchdog: define LOADER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_fill_loader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ROWS        = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           address,
    output logic                  read,
    input  logic [63:0]           readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ROWS-1:0]       wrreq_A,
    output logic                  wrreq_B,
    input  logic [ROWS-1:0]       wrfull_A,
    input  logic                  wrfull_B
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_PUSH = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // word_idx runs 0..ROWS (B word then one word per A row)
    localparam logic [3:0] C_LAST_WORD = 4'(ROWS);
    localparam logic [3:0] C_LAST_BYTE = 4'(ROWS - 1);

    state_t          state_q, state_d;
    logic [3:0]      word_idx_q, word_idx_d;
    logic [3:0]      byte_idx_q, byte_idx_d;
    logic [63:0]     word_q, word_d;
    logic            err_q, err_d;
    logic            busy_q, done_q, read_q;

    logic [DATA_WIDTH-1:0] w_cur_byte;
    logic                  w_target_full;

`ifdef LOADER_TIMEOUT_EN
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tmo_q, tmo_d;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign read    = read_q;
    assign err     = err_q;
    assign address = BASE_ADDR + {28'd0, word_idx_q};

    // Select the byte lane addressed by byte_idx (LSB byte first)
    always_comb begin
        w_cur_byte = '0;
        for (int k = 0; k < int'(ROWS); k++) begin
            if (byte_idx_q == 4'(k)) begin
                w_cur_byte = word_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FIFO strobes: only the target FIFO is written, and never while it is full
    always_comb begin
        wr_data       = '0;
        wrreq_A       = '0;
        wrreq_B       = 1'b0;
        w_target_full = 1'b0;
        if (state_q == S_PUSH) begin
            wr_data = w_cur_byte;
            if (word_idx_q == 4'd0) begin
                w_target_full = wrfull_B;
                wrreq_B       = !wrfull_B;
            end
            for (int r = 0; r < int'(ROWS); r++) begin
                if (word_idx_q == 4'(r + 1)) begin
                    w_target_full = wrfull_A[r];
                    wrreq_A[r]    = !wrfull_A[r];
                end
            end
        end
    end

    // Next-state and datapath update for the fetch/unpack sequence
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        err_d      = err_q;
`ifdef LOADER_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (!waitrequest) begin
                    state_d = S_WAIT;
`ifdef LOADER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (readdatavalid) begin
                    word_d  = readdata;
                    state_d = S_PUSH;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (tmo_q == C_TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_PUSH: begin
                // A full target stalls the byte in place, including the last one
                if (!w_target_full) begin
                    if (byte_idx_q == C_LAST_BYTE) begin
                        if (word_idx_q == C_LAST_WORD) begin
                            state_d = S_DONE;
                        end else begin
                            word_idx_d = word_idx_q + 4'd1;
                            byte_idx_d = '0;
                            state_d    = S_REQ;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with registered status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            read_q     <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            err_q      <= err_d;
            busy_q     <= (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_PUSH);
            done_q     <= (state_d == S_DONE);
            read_q     <= (state_d == S_REQ);
`ifdef LOADER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_fill_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_fill_loader
//  Description : Self-checking bench for matrix_fill_loader. A memory model
//                answers reads, FIFO writes are captured per target and
//                compared with the words the memory handed out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_fill_loader;

    localparam int          ROWS = 8;
    localparam int          DW   = 8;
    localparam logic [31:0] BASE = 32'h0;

    logic            clk = 1'b0;
    logic            rst_n, start, busy, done, err, read;
    logic [31:0]     address;
    logic [63:0]     readdata;
    logic            readdatavalid, waitrequest;
    logic [DW-1:0]   wr_data;
    logic [ROWS-1:0] wrreq_A, wrfull_A;
    logic            wrreq_B, wrfull_B;

    always #5 clk = ~clk;

    matrix_fill_loader #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .BASE_ADDR  (BASE),
        .TIMEOUT_CYC(255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .address      (address),
        .read         (read),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .waitrequest  (waitrequest),
        .wr_data      (wr_data),
        .wrreq_A      (wrreq_A),
        .wrreq_B      (wrreq_B),
        .wrfull_A     (wrfull_A),
        .wrfull_B     (wrfull_B)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory image and captured FIFO contents
    logic [63:0] mem [0:ROWS];
    logic [63:0] capB;
    int          nB;
    logic [63:0] capA [ROWS];
    int          nA [ROWS];
    int          acc_addr [$];
    int          read_cyc [0:ROWS];
    int          viol;

    // Scenario knobs
    int cfg_wait_pct, cfg_full_pct, cfg_lat;
    bit cfg_noise;
    int cfg_stall_word, cfg_stall_n, cfg_full_word, cfg_full_row, cfg_full_n;
    int cfg_rst_word, cfg_drop_word;
    int full_seen;

    typedef struct {
        int wait_pct;
        int full_pct;
        int lat;
        bit noise;
        bit rnd_mem;
        int exp_cycles;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_defaults();
        cfg_wait_pct = 0; cfg_full_pct = 0; cfg_lat = 1; cfg_noise = 0;
        cfg_stall_word = -1; cfg_stall_n = 0;
        cfg_full_word = -1; cfg_full_row = 0; cfg_full_n = 0;
        cfg_rst_word = -1; cfg_drop_word = -1;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int n = 0; n <= ROWS; n++) begin
            for (int k = 0; k < ROWS; k++) begin
                mem[n][k*8 +: 8] = rnd ? 8'($urandom) : 8'(n + k);
            end
        end
    endtask

    task automatic clear_caps();
        capB = '0; nB = 0; viol = 0; full_seen = 0;
        acc_addr.delete();
        for (int r = 0; r < ROWS; r++) begin capA[r] = '0; nA[r] = 0; end
        for (int n = 0; n <= ROWS; n++) read_cyc[n] = 0;
    endtask

    // Record FIFO writes seen this cycle and check per-cycle invariants
    task automatic observe_writes(output int wr_cnt);
        wr_cnt = 0;
        if (busy && done) viol++;
        if (wrreq_B && wrfull_B) viol++;
        if ((wrreq_A & wrfull_A) != '0) viol++;
        if ($countones({wrreq_A, wrreq_B}) > 1) viol++;
        if (wrreq_B) begin
            if (nB < ROWS) capB[nB*8 +: 8] = wr_data;
            nB++; wr_cnt++;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (wrreq_A[r]) begin
                if (nA[r] < ROWS) capA[r][nA[r]*8 +: 8] = wr_data;
                nA[r]++; wr_cnt++;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 0; readdatavalid = 0; waitrequest = 0; wrfull_A = '0; wrfull_B = 0;
            @(negedge clk);
            observe_writes(w);
            if (w != 0) viol++;
        end
    endtask

    // One load: pulse start, then play memory slave and FIFO-full source
    task automatic run_load(output int cycles, output bit finished);
        int c, pushes_left, ret_in, ret_word, cur_word, stall_seen, wr_cnt, a;
        bit ret_now, full_forced;
        logic [63:0] ret_data;
        pushes_left = 0; ret_in = 0; ret_word = 0; cur_word = -1; stall_seen = 0;
        ret_data = '0; cycles = -1; finished = 0;
        @(posedge clk); #1;
        start = 1; rst_n = 1; readdatavalid = 0; waitrequest = 0; wrfull_A = '0; wrfull_B = 0;
        c = -1;
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk); #1;
            c++;
            ret_now = 0; full_forced = 0;
            start = cfg_noise && busy && ($urandom_range(0, 7) == 0);
            rst_n = !(cfg_rst_word >= 0 && cur_word == cfg_rst_word && pushes_left == 4);
            waitrequest = ($urandom_range(0, 99) < cfg_wait_pct);
            if (cfg_stall_word >= 0 && read && address == BASE + 32'(cfg_stall_word)
                && stall_seen < cfg_stall_n) waitrequest = 1;
            readdatavalid = 0;
            readdata = {$urandom, $urandom};
            if (ret_in > 0) begin
                ret_in--;
                if (ret_in == 0) begin readdatavalid = 1; readdata = ret_data; ret_now = 1; end
            end else if (cfg_noise && (read || pushes_left > 0) && $urandom_range(0, 3) == 0) begin
                readdatavalid = 1;
            end
            for (int r = 0; r < ROWS; r++) wrfull_A[r] = ($urandom_range(0, 99) < cfg_full_pct);
            wrfull_B = ($urandom_range(0, 99) < cfg_full_pct);
            if (pushes_left > 0 && pushes_left <= 5 && cur_word == cfg_full_word && full_seen < cfg_full_n) begin
                wrfull_A = '0; wrfull_A[cfg_full_row] = 1; full_forced = 1;
            end
            @(negedge clk);
            observe_writes(wr_cnt);
            if (pushes_left > 0) pushes_left -= wr_cnt;
            else if (wr_cnt > 0) viol++;
            if (full_forced) full_seen++;
            if (cfg_stall_word >= 0 && read && waitrequest && address == BASE + 32'(cfg_stall_word)) stall_seen++;
            a = int'(address - BASE);
            if (read && a >= 0 && a <= ROWS) read_cyc[a]++;
            if (read && !waitrequest) begin
                acc_addr.push_back(a);
                ret_word = a;
                if (a != cfg_drop_word) begin
                    ret_in = cfg_lat;
                    ret_data = (a >= 0 && a <= ROWS) ? mem[a] : 64'h0;
                end
            end
            if (ret_now) begin pushes_left = ROWS; cur_word = ret_word; end
            if (!rst_n) begin cycles = c; break; end
            if (done) begin cycles = c; finished = 1; break; end
        end
    endtask

    task automatic check_full_load(input string tag);
        int bad;
        chk({tag, "_B_count"}, 64'(nB), 64'(ROWS));
        chk({tag, "_B_data"}, capB, mem[0]);
        for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("%s_A%0d_count", tag, r), 64'(nA[r]), 64'(ROWS));
            chk($sformatf("%s_A%0d_data", tag, r), capA[r], mem[r+1]);
        end
        bad = (acc_addr.size() != ROWS + 1) ? 1 : 0;
        foreach (acc_addr[i]) if (acc_addr[i] != i) bad++;
        chk({tag, "_accept_seq_errors"}, 64'(bad), 64'd0);
        chk({tag, "_invariant_violations"}, 64'(viol), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    vec_t vecs[6];
    int   cyc;
    bit   fin;
    int   w;

    initial begin
        vecs[0] = '{0,  0,  1, 0, 0, 90};
        vecs[1] = '{0,  0,  3, 0, 1, 108};
        vecs[2] = '{30, 0,  1, 0, 1, -1};
        vecs[3] = '{0,  30, 2, 0, 1, -1};
        vecs[4] = '{25, 25, 1, 1, 1, -1};
        vecs[5] = '{40, 40, 2, 1, 1, -1};

        cfg_defaults();
        clear_caps();
        rst_n = 0; start = 1; readdatavalid = 1; readdata = 64'hDEAD_BEEF_0BAD_F00D;
        waitrequest = 0; wrfull_A = '0; wrfull_B = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_read", 64'(read), 0);
        chk("rst_address", 64'(address), 64'(BASE));
        chk("rst_wr_data", 64'(wr_data), 0);
        chk("rst_wrreq", 64'({wrreq_A, wrreq_B}), 0);
        @(posedge clk); #1;
        rst_n = 1; start = 0;
        idle_cycles(2);
        chk("idle_stays_idle", 64'({busy, done, read}), 0);

        // Table-driven loads
        for (int v = 0; v < 6; v++) begin
            cfg_defaults();
            cfg_wait_pct = vecs[v].wait_pct;
            cfg_full_pct = vecs[v].full_pct;
            cfg_lat      = vecs[v].lat;
            cfg_noise    = vecs[v].noise;
            fill_mem(vecs[v].rnd_mem);
            clear_caps();
            run_load(cyc, fin);
            chk($sformatf("v%0d_finished", v), 64'(fin), 1);
            if (vecs[v].exp_cycles >= 0) chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].exp_cycles));
            check_full_load($sformatf("v%0d", v));
            idle_cycles(3);
            chk($sformatf("v%0d_done_hold", v), 64'({done, busy}), 64'b10);
        end

        // waitrequest held for 3 cycles on word 4
        cfg_defaults(); cfg_stall_word = 4; cfg_stall_n = 3;
        fill_mem(0); clear_caps();
        run_load(cyc, fin);
        chk("wreq_finished", 64'(fin), 1);
        chk("wreq_cycles", 64'(cyc), 93);
        chk("wreq_read_cycles_w4", 64'(read_cyc[4]), 4);
        check_full_load("wreq");

        // A row 2 full for 5 cycles during word 3 push
        cfg_defaults(); cfg_full_word = 3; cfg_full_row = 2; cfg_full_n = 5;
        fill_mem(0); clear_caps();
        run_load(cyc, fin);
        chk("full_finished", 64'(fin), 1);
        chk("full_cycles", 64'(cyc), 95);
        chk("full_stall_cycles", 64'(full_seen), 5);
        check_full_load("full");

        // Reset mid-push of word 5, stale return afterwards, then reload
        cfg_defaults(); cfg_rst_word = 5;
        fill_mem(1); clear_caps();
        run_load(cyc, fin);
        chk("rst_mid_aborted", 64'(fin), 0);
        @(posedge clk); #1;
        rst_n = 1; start = 0; readdatavalid = 1; readdata = {$urandom, $urandom};
        wrfull_A = '0; wrfull_B = 0; waitrequest = 0;
        @(negedge clk);
        chk("rst_mid_outputs", 64'({busy, done, err, read, wr_data, wrreq_A, wrreq_B}), 0);
        chk("rst_mid_address", 64'(address), 64'(BASE));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            readdatavalid = 1; readdata = {$urandom, $urandom};
            @(negedge clk);
            observe_writes(w);
            chk($sformatf("stale_ignored_%0d", i), 64'({busy, w[7:0]}), 0);
        end
        cfg_defaults(); clear_caps();
        run_load(cyc, fin);
        chk("reload_finished", 64'(fin), 1);
        chk("reload_cycles", 64'(cyc), 90);
        check_full_load("reload");

`ifdef LOADER_TIMEOUT_EN
        // Word 2 never returns: watchdog aborts into DONE with err
        cfg_defaults(); cfg_drop_word = 2;
        fill_mem(0); clear_caps();
        run_load(cyc, fin);
        chk("tmo_finished", 64'(fin), 1);
        chk("tmo_cycles", 64'(cyc), 276);
        chk("tmo_err", 64'(err), 1);
        chk("tmo_B", capB, mem[0]);
        chk("tmo_A0", capA[0], mem[1]);
        chk("tmo_A1_count", 64'(nA[1]), 0);
        cfg_defaults(); clear_caps();
        run_load(cyc, fin);
        chk("tmo_restart_finished", 64'(fin), 1);
        check_full_load("tmo_restart");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
